// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Purpose  : Shared FSM encoding and lane/counter widths for dmem_responder.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } dmem_state_e;

  localparam int LANE_W     = 8;
  localparam int NUM_LANES  = 4;
  localparam int WAIT_CNT_W = 4;

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_byte_ram.sv
`default_nettype none
// ============================================================================
// Module   : dmem_byte_ram
// Purpose  : Four byte-wide RAM lanes with per-lane write enable and an
//            asynchronous read port; the caller registers the read data.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_byte_ram
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic                        clk,
  input  logic [ADDR_W-1:0]           rd_addr,
  output logic [NUM_LANES*LANE_W-1:0] rd_data,
  input  logic                        wr_en,
  input  logic [ADDR_W-1:0]           wr_addr,
  input  logic [NUM_LANES-1:0]        wr_be,
  input  logic [NUM_LANES*LANE_W-1:0] wr_data
);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic [LANE_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
      if (wr_en && wr_be[g]) begin
        mem[wr_addr] <= wr_data[g*LANE_W +: LANE_W];
      end
    end

    assign rd_data[g*LANE_W +: LANE_W] = mem[rd_addr];
  end

endmodule : dmem_byte_ram
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Data-port memory responder: fixed wait states, one-cycle ack,
//            byte-lane writes committed on the edge leaving ACK.
//            Optional out-of-range detection when DMEM_ERR_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] addr,
  input  logic [3:0]  byte_en,
  input  logic [31:0] write_data,
  output logic [31:0] read_data_M,
  output logic        data_mem_ack
`ifdef DMEM_ERR_EN
  ,
  output logic        mem_err
`endif
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_INIT =
    (WAIT_STATES == 0) ? '0 : WAIT_CNT_W'(WAIT_STATES - 1);

  dmem_state_e           state_q, state_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  we_q, we_d;
  logic [3:0]            be_q, be_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  oor_q, oor_d;
  logic [31:0]           read_data_q, read_data_d;
  logic                  ack_q, ack_d;
  logic                  mem_err_q, mem_err_d;

  logic                  req_oor;
  logic                  ram_we;
  logic [ADDR_W-1:0]     ram_rd_addr;
  logic [31:0]           ram_rd_data;
  logic                  unused_bits;

`ifdef DMEM_ERR_EN
  assign req_oor     = |addr[31:ADDR_W+2];
  assign mem_err     = mem_err_q;
  assign unused_bits = ^addr[1:0];
`else
  assign req_oor     = 1'b0;
  assign unused_bits = ^{addr[1:0], addr[31:ADDR_W+2], mem_err_q};
`endif

  // In IDLE the zero-wait path must read the word being requested right now.
  assign ram_rd_addr = (state_q == IDLE) ? addr[ADDR_W+1:2] : addr_q;

  dmem_byte_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rd_addr (ram_rd_addr),
    .rd_data (ram_rd_data),
    .wr_en   (ram_we && !reset),
    .wr_addr (addr_q),
    .wr_be   (be_q),
    .wr_data (wdata_q)
  );

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    addr_d      = addr_q;
    we_d        = we_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    oor_d       = oor_q;
    read_data_d = read_data_q;
    ack_d       = 1'b0;
    mem_err_d   = 1'b0;
    ram_we      = 1'b0;

    case (state_q)
      IDLE: begin
        if (mem_req) begin
          addr_d  = addr[ADDR_W+1:2];
          we_d    = mem_we;
          be_d    = byte_en;
          wdata_d = write_data;
          oor_d   = req_oor;
          if (WAIT_STATES == 0) begin
            state_d     = ACK;
            ack_d       = 1'b1;
            mem_err_d   = req_oor;
            read_data_d = req_oor ? '0 : ram_rd_data;
          end else begin
            state_d    = WAIT;
            wait_cnt_d = WAIT_INIT;
          end
        end
      end

      WAIT: begin
        if (!mem_req) begin
          state_d    = IDLE;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == '0) begin
          state_d     = ACK;
          ack_d       = 1'b1;
          mem_err_d   = oor_q;
          read_data_d = oor_q ? '0 : ram_rd_data;
        end else begin
          wait_cnt_d = wait_cnt_q - WAIT_CNT_W'(1);
        end
      end

      ACK: begin
        state_d = IDLE;
        ram_we  = we_q && !oor_q;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      be_q        <= '0;
      wdata_q     <= '0;
      oor_q       <= 1'b0;
      read_data_q <= '0;
      ack_q       <= 1'b0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      oor_q       <= oor_d;
      read_data_q <= read_data_d;
      ack_q       <= ack_d;
      mem_err_q   <= mem_err_d;
    end
  end

  assign read_data_M  = read_data_q;
  assign data_mem_ack = ack_q;

endmodule : dmem_responder
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Purpose  : Self-checking bench: a 2-wait-state instance and a 0-wait-state
//            instance checked against a word-array reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

  logic        clk, reset;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wd0, addr1, wd1;
  logic [3:0]  be0, be1;
  logic [31:0] rd0, rd1;
  logic        ack0, ack1, err0, err1;

  int checks = 0;
  int errors = 0;
  logic [31:0] model [2][1024];

  dmem_responder #(.ADDR_W(10), .WAIT_STATES(2)) u_dut0 (
    .clk(clk), .reset(reset), .mem_req(req0), .mem_we(we0), .addr(addr0),
    .byte_en(be0), .write_data(wd0), .read_data_M(rd0), .data_mem_ack(ack0)
`ifdef DMEM_ERR_EN
    , .mem_err(err0)
`endif
  );

  dmem_responder #(.ADDR_W(10), .WAIT_STATES(0)) u_dut1 (
    .clk(clk), .reset(reset), .mem_req(req1), .mem_we(we1), .addr(addr1),
    .byte_en(be1), .write_data(wd1), .read_data_M(rd1), .data_mem_ack(ack1)
`ifdef DMEM_ERR_EN
    , .mem_err(err1)
`endif
  );

`ifndef DMEM_ERR_EN
  assign err0 = 1'b0;
  assign err1 = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic get_ack(input int d);
    return (d == 0) ? ack0 : ack1;
  endfunction
  function automatic logic [31:0] get_rd(input int d);
    return (d == 0) ? rd0 : rd1;
  endfunction
  function automatic logic get_err(input int d);
    return (d == 0) ? err0 : err1;
  endfunction
  function automatic logic exp_oor(input logic [31:0] a);
`ifdef DMEM_ERR_EN
    return a[31:12] != 20'd0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic drive(input int d, input logic req, input logic we, input logic [31:0] a,
                       input logic [3:0] be, input logic [31:0] wd);
    if (d == 0) begin req0 = req; we0 = we; addr0 = a; be0 = be; wd0 = wd; end
    else        begin req1 = req; we1 = we; addr1 = a; be1 = be; wd1 = wd; end
  endtask

  task automatic model_write(input int d, input logic [31:0] a, input logic [3:0] be,
                             input logic [31:0] wd);
    for (int i = 0; i < 4; i++)
      if (be[i]) model[d][a[11:2]][8*i +: 8] = wd[8*i +: 8];
  endtask

  // Counts edges from the request's sampling edge until ack is seen (0 = timeout).
  task automatic wait_ack(input int d, output int lat);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (get_ack(d)) begin lat = i; break; end
    end
  endtask

  // Full transaction from an IDLE cycle; ends in the next IDLE cycle.
  task automatic txn(input int d, input logic we, input logic [31:0] a, input logic [3:0] be,
                     input logic [31:0] wd, output logic [31:0] rd);
    int lat;
    logic oor;
    oor = exp_oor(a);
    drive(d, 1'b1, we, a, be, wd);
    wait_ack(d, lat);
    rd = get_rd(d);
    chk($sformatf("latency_d%0d", d), 32'(lat), (d == 0) ? 32'd3 : 32'd1);
    chk("mem_err_at_ack", {31'd0, get_err(d)}, {31'd0, oor});
    if (oor) chk("oor_read_zero", rd, 32'd0);
    if (we && !oor) model_write(d, a, be, wd);
    drive(d, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    @(posedge clk); #1;
    chk("ack_one_cycle", {31'd0, get_ack(d)}, 32'd0);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [12];

  initial begin
    logic [31:0] rd;
    int lat, n;

    tbl[0]  = '{1'b1, 32'h10,  4'hF, 32'hDEADBEEF, 32'h0};
    tbl[1]  = '{1'b0, 32'h10,  4'h0, 32'h0,        32'hDEADBEEF};
    tbl[2]  = '{1'b1, 32'h20,  4'hF, 32'hAABBCCDD, 32'h0};
    tbl[3]  = '{1'b1, 32'h20,  4'h5, 32'h11223344, 32'h0};
    tbl[4]  = '{1'b0, 32'h23,  4'h0, 32'h0,        32'hAA22CC44};
    tbl[5]  = '{1'b1, 32'h24,  4'hF, 32'h55667788, 32'h0};
    tbl[6]  = '{1'b1, 32'h24,  4'h0, 32'h12345678, 32'h0};
    tbl[7]  = '{1'b0, 32'h24,  4'h3, 32'h0,        32'h55667788};
    tbl[8]  = '{1'b1, 32'h100, 4'hF, 32'h0F0F0F0F, 32'h0};
    tbl[9]  = '{1'b1, 32'h104, 4'hF, 32'h76543210, 32'h0};
    tbl[10] = '{1'b1, 32'h0,   4'hF, 32'h00C0FFEE, 32'h0};
    tbl[11] = '{1'b0, 32'h105, 4'h0, 32'h0,        32'h76543210};

    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_ack", {31'd0, ack0}, 32'd0);
    chk("reset_rd", rd0, 32'd0);
    chk("reset_err", {31'd0, err0}, 32'd0);
    chk("reset_ack_ws0", {31'd0, ack1}, 32'd0);

    foreach (tbl[i]) begin
      txn(0, tbl[i].we, tbl[i].addr, tbl[i].be, tbl[i].wd, rd);
      if (!tbl[i].we) chk($sformatf("table_rd_%0d", i), rd, tbl[i].exp);
    end

    // Out-of-range write aliases onto word 0 unless error detection is built in.
    txn(0, 1'b1, 32'h1000, 4'hF, 32'hCAFEF00D, rd);
    txn(0, 1'b0, 32'h0, 4'h0, 32'h0, rd);
`ifdef DMEM_ERR_EN
    chk("oor_word0_kept", rd, 32'h00C0FFEE);
`else
    chk("alias_word0", rd, 32'hCAFEF00D);
`endif

    // Flush during WAIT: no ack, no write.
    drive(0, 1'b1, 1'b1, 32'h100, 4'hF, 32'hFFFFFFFF);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    n = 0;
    repeat (6) begin @(posedge clk); #1; if (ack0) n++; end
    chk("abort_no_ack", 32'(n), 32'd0);
    txn(0, 1'b0, 32'h100, 4'h0, 32'h0, rd);
    chk("abort_old_value", rd, 32'h0F0F0F0F);

    // Reset during WAIT.
    drive(0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_wait_ack", {31'd0, ack0}, 32'd0);
    chk("rst_wait_rd", rd0, 32'd0);
    txn(0, 1'b0, 32'h10, 4'h0, 32'h0, rd);
    chk("rst_wait_then_rd", rd, model[0][4]);

    // Reset during ACK of a write discards the write.
    drive(0, 1'b1, 1'b1, 32'h104, 4'hF, 32'h0BADF00D);
    wait_ack(0, lat);
    chk("rst_ack_latency", 32'(lat), 32'd3);
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    txn(0, 1'b0, 32'h104, 4'h0, 32'h0, rd);
    chk("rst_ack_write_dropped", rd, 32'h76543210);

    // Zero-wait instance: single read, then back-to-back write/read.
    txn(1, 1'b1, 32'h14, 4'hF, 32'h13579BDF, rd);
    txn(1, 1'b0, 32'h14, 4'h0, 32'h0, rd);
    chk("ws0_read", rd, 32'h13579BDF);
    drive(1, 1'b1, 1'b1, 32'h14, 4'h3, 32'hAAAA5555);
    wait_ack(1, lat);
    chk("ws0_b2b_first_lat", 32'(lat), 32'd1);
    drive(1, 1'b1, 1'b0, 32'h14, 4'h0, 32'h0);
    wait_ack(1, lat);
    chk("ws0_b2b_spacing", 32'(lat), 32'd2);
    chk("ws0_b2b_data", rd1, 32'h13575555);
    drive(1, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    @(posedge clk); #1;

    // Randomized traffic over 16 words against the model.
    for (int w = 0; w < 16; w++) txn(0, 1'b1, 32'(w) << 2, 4'hF, $urandom, rd);
    for (int i = 0; i < 60; i++) begin
      logic        rwe;
      logic [31:0] ra;
      rwe = 1'($urandom_range(0, 1));
      ra  = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      txn(0, rwe, ra, 4'($urandom_range(0, 15)), $urandom, rd);
      if (!rwe) chk($sformatf("rand_rd_%0d", i), rd, model[0][ra[11:2]]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_dmem_responder
`default_nettype wire
